uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the core's data bus, downstream of the core alongside the main memory. The address decode selects it by a small address window. Core stores to its data register push bytes into a transmit FIFO. A baud-rate FSM serialises the bytes as 8N1 frames on `tx_o`. A status register lets software poll FIFO and line state.

---
 rtl/uart_tx_mmio.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 transmitter with a transmit FIFO.
// TXDATA at +0x0 queues bytes, STATUS at +0x4 reports FIFO/line state.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        tx_o
);
  localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LEN_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CPB - 1);
  localparam logic [LEN_W-1:0] DEPTH    = LEN_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LEN_W-1:0] count_q;
  logic             ovf_q, ack_q;
  logic [31:0]      data_q;

  logic        hit, wr_acc, rd_acc, sel_stat;
  logic        full, empty, push, pop;
  logic [7:0]  cnt8;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{data_i[31:8], addr_i[1:0]};

  // Bus decode: a write wins when both strobes are high.
  assign hit      = (rd_en_i | wr_en_i) &&
                    (addr_i[31:3] == BASE_ADDR[31:3]);
  assign wr_acc   = hit & wr_en_i;
  assign rd_acc   = hit & ~wr_en_i;
  assign sel_stat = addr_i[2];

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  assign push  = wr_acc & ~sel_stat & ~full;

  assign cnt8   = 8'(count_q);
  assign status = {16'h0, cnt8, 4'h0, ovf_q, empty, full,
                   state_q != IDLE};

  // FIFO storage; reset only needs to clear the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + LEN_W'(push) - LEN_W'(pop);
    end
  end

  // Bus response, read data capture and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ack_q <= hit;
      if (rd_acc) data_q <= sel_stat ? status : 32'h0;
      if (wr_acc & ~sel_stat & full) ovf_q <= 1'b1;
      else if (rd_acc & sel_stat)    ovf_q <= 1'b0;
    end
  end

  // FSM state register, baud/bit counters and registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // FSM next state: pop in IDLE, then start/8 data/stop bit times.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output: line level for the upcoming state, so tx_o is a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign tx_o   = tx_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench for uart_tx_mmio at 10 clocks/bit.
// A line monitor decodes frames; scenario tasks compare against expectations.
module tb_uart_tx_mmio;
  localparam int CPB = 10;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rd_en_i(rd_en), .wr_en_i(wr_en),
    .addr_i(addr), .data_i(wdata), .data_o(rdata),
    .ack_o(ack), .tx_o(tx)
  );

  typedef struct {
    logic [7:0] data;
    bit         shape_ok;
    int         gap;
  } frame_t;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Line monitor: frames must hold each bit level for exactly CPB cycles.
  initial begin : monitor
    int k;
    int idle;
    logic cur;
    frame_t f;
    k = -1;
    idle = 0;
    cur = 1'b1;
    f.data = '0;
    f.shape_ok = 1'b1;
    f.gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = -1;
        idle = 0;
      end else if (k < 0) begin
        if (tx === 1'b0) begin
          k = 1;
          cur = 1'b0;
          f.data = '0;
          f.shape_ok = 1'b1;
          f.gap = idle;
          idle = 0;
        end else begin
          idle++;
        end
      end else begin
        if (k % CPB == 0) begin
          cur = tx;
          if (k / CPB >= 1 && k / CPB <= 8) f.data[k/CPB-1] = tx;
          if (k / CPB == 9 && tx !== 1'b1) f.shape_ok = 1'b0;
        end else if (tx !== cur) begin
          f.shape_ok = 1'b0;
        end
        if (k == 10 * CPB - 1) begin
          rx_q.push_back(f);
          k = -1;
        end else begin
          k++;
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: run did not end, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic ack_s, output logic [31:0] data_s);
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    ack_s = ack;
    data_s = rdata;
  endtask

  // Consecutive-cycle TXDATA writes from an idle, empty FIFO; a small
  // occupancy model decides which bytes are accepted.
  task automatic burst_write(input logic [7:0] b [16], input int n,
                             output int acks);
    int occ;
    bit idle_m, push_m, pop_m;
    occ = 0; idle_m = 1'b1; acks = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; rd_en = 1'b0; addr = BASE;
      wdata = {24'hC0FFEE, b[i]};
      push_m = (occ < DEPTH);
      pop_m = idle_m && (occ > 0);
      if (push_m) exp_q.push_back(b[i]);
      occ = occ + int'(push_m) - int'(pop_m);
      if (pop_m) idle_m = 1'b0;
      @(negedge clk);
      if (i > 0 && ack === 1'b1) acks++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    if (ack === 1'b1) acks++;
  endtask

  task automatic wait_frames(input int n, input int bound, output bit ok);
    int t = 0;
    while (rx_q.size() < n && t < bound) begin
      @(negedge clk);
      t++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    logic a; logic [31:0] d; int bad;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", rdata);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_idle: %0d bad cycles want 0", bad);
    end
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h4) begin
      errors++; $display("FAIL reset_status: ack=%b data=%h want 1/4", a, d);
    end
  endtask

  task automatic test_single();
    logic a; logic [31:0] d; bit ok; frame_t f; logic [7:0] e;
    exp_q.push_back(8'hA5);
    access(1'b0, 1'b1, BASE, 32'hFFFF_FFA5, a, d);
    checks++;
    if (a !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL single_ack: ack=%b tx=%b want 1/1", a, tx);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || tx !== 1'b0) begin
      errors++; $display("FAIL single_latency: ack=%b tx=%b want 0/0", ack, tx);
    end
    wait_frames(1, 200, ok);
    checks++;
    if (!ok || exp_q.size() != 1) begin
      errors++; $display("FAIL single_frame: frames=%0d want 1", rx_q.size());
    end else begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (!f.shape_ok || f.data !== e) begin
        errors++;
        $display("FAIL single_data: got %h shape=%0d want %h", f.data, f.shape_ok, e);
      end
    end
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (d !== 32'h4) begin
      errors++; $display("FAIL single_status: got %h want 4", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [16]; int acks; logic a; logic [31:0] d;
    bit ok; frame_t f; logic [7:0] e;
    idle_cycles(5);
    foreach (b[i]) b[i] = 8'h0;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    burst_write(b, 3, acks);
    checks++;
    if (acks != 3) begin
      errors++; $display("FAIL b2b_acks: got %0d want 3", acks);
    end
    wait_frames(1, 300, ok);
    idle_cycles(50);
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (d !== 32'h0000_0101) begin
      errors++; $display("FAIL b2b_status: got %h want 00000101", d);
    end
    wait_frames(3, 400, ok);
    checks++;
    if (!ok || exp_q.size() != 3) begin
      errors++; $display("FAIL b2b_frames: got %0d want 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (!f.shape_ok || f.data !== e || (i > 0 && f.gap != 1)) begin
          errors++;
          $display("FAIL b2b_frame%0d: got %h shape=%0d gap=%0d want %h gap 1",
                   i, f.data, f.shape_ok, f.gap, e);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b [16]; int acks; logic a; logic [31:0] d;
    bit ok; frame_t f; logic [7:0] e;
    idle_cycles(5);
    foreach (b[i]) b[i] = 8'(i + 1);
    burst_write(b, 10, acks);
    checks++;
    if (acks != 10 || exp_q.size() != 9) begin
      errors++; $display("FAIL ovf_acks: got %0d want 10", acks);
    end
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (d !== 32'h0000_080B) begin
      errors++; $display("FAIL ovf_status1: got %h want 0000080b", d);
    end
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (d !== 32'h0000_0803) begin
      errors++; $display("FAIL ovf_status2: got %h want 00000803", d);
    end
    wait_frames(9, 9 * 101 + 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ovf_frames: got %0d want 9", rx_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (!f.shape_ok || f.data !== e) begin
          errors++;
          $display("FAIL ovf_frame%0d: got %h shape=%0d want %h",
                   i, f.data, f.shape_ok, e);
        end
      end
    end
    idle_cycles(150);
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (rx_q.size() != 0 || d !== 32'h4) begin
      errors++;
      $display("FAIL ovf_drain: extra=%0d status=%h want 0/4", rx_q.size(), d);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b [16]; int acks; logic a; logic [31:0] d; int low;
    idle_cycles(5);
    foreach (b[i]) b[i] = 8'h0;
    b[0] = 8'hA5; b[1] = 8'h3C; b[2] = 8'hF0;
    burst_write(b, 3, acks);
    idle_cycles(43);
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL mid_bit3: tx=%b want 0", tx);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ack !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: tx=%b ack=%b data=%h want 1/0/0", tx, ack, rdata);
    end
    low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    checks++;
    if (low != 0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL mid_quiet: low=%0d frames=%0d want 0/0", low, rx_q.size());
    end
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (d !== 32'h4) begin
      errors++; $display("FAIL mid_status: got %h want 4", d);
    end
  endtask

  task automatic test_decode();
    logic a; logic [31:0] d; int low;
    access(1'b1, 1'b0, BASE + 7, 0, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h4) begin
      errors++; $display("FAIL dec_lowbits: ack=%b data=%h want 1/4", a, d);
    end
    access(1'b0, 1'b1, BASE + 8, 32'h77, a, d);
    checks++;
    if (a !== 1'b0 || d !== 32'h4) begin
      errors++; $display("FAIL dec_above: ack=%b data=%h want 0/4", a, d);
    end
    access(1'b0, 1'b1, BASE - 4, 32'h66, a, d);
    checks++;
    if (a !== 1'b0) begin
      errors++; $display("FAIL dec_below: ack=%b want 0", a);
    end
    access(1'b1, 1'b0, BASE, 0, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL dec_txread: ack=%b data=%h want 1/0", a, d);
    end
    access(1'b1, 1'b1, BASE + 4, 32'h55, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL dec_rdwr: ack=%b data=%h want 1/0", a, d);
    end
    low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    access(1'b1, 1'b0, BASE + 4, 0, a, d);
    checks++;
    if (low != 0 || d !== 32'h4) begin
      errors++; $display("FAIL dec_nochange: low=%0d status=%h want 0/4", low, d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
